audio_uart_tx: RTL and testbench

Serialises 18-bit audio samples onto an RS232 line as three 8N1 UART bytes, least-significant byte first. It is the transmit-side counterpart of the dacboard audio receive path and runs in the main 12 MHz domain. It serves as host loopback, as a sample-capture uplink, and as a synthesisable stimulus source for dacboard.

---
 rtl/audio_uart_tx.sv | 142 ++++++++++++++
 tb/tb_audio_uart_tx.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/audio_uart_tx.sv
// audio_uart_tx: serialises an 18-bit audio sample as three back-to-back
// 8N1 UART bytes (LSB byte first) on a registered, idle-high RS232 line.
`timescale 1ns/1ps
module audio_uart_tx #(
    parameter int unsigned CLK_FREQ = 12_000_000,
    parameter int unsigned BAUD     = 115_200,
    parameter int unsigned DIV      = CLK_FREQ / BAUD
) (
    input  logic        CLK_IN,
    input  logic        RST_i,
    input  logic [17:0] sample_i,
    input  logic        valid_i,
    output logic        ready_o,
    output logic        RS232_TX_o,
    output logic        busy_o,
    output logic        frame_done_o
);

    localparam int unsigned     CW        = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0]   BAUD_LAST = CW'(DIV - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t         state_q, state_n;
    logic [CW-1:0]  baud_q, baud_n;
    logic [2:0]     bit_q, bit_n;
    logic [1:0]     byte_q, byte_n;
    logic [17:0]    hold_q, hold_n;
    logic           tx_q, tx_n;
    logic           done_q, done_n;
    logic           bit_end;
    logic [7:0]     cur_byte;

    // Byte index 2 carries only the two top sample bits, zero-padded.
    function automatic logic [7:0] byte_sel(input logic [17:0] s, input logic [1:0] idx);
        case (idx)
            2'd0:    return s[7:0];
            2'd1:    return s[15:8];
            default: return {6'b0, s[17:16]};
        endcase
    endfunction

    assign bit_end      = (baud_q == BAUD_LAST);
    assign cur_byte     = byte_sel(hold_n, byte_n);
    assign ready_o      = (state_q == IDLE);
    assign busy_o       = ~ready_o;
    assign RS232_TX_o   = tx_q;
    assign frame_done_o = done_q;

    // State, counters, holding register and registered line/pulse outputs.
    always_ff @(posedge CLK_IN or posedge RST_i) begin
        if (RST_i) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            hold_q  <= '0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            baud_q  <= baud_n;
            bit_q   <= bit_n;
            byte_q  <= byte_n;
            hold_q  <= hold_n;
            tx_q    <= tx_n;
            done_q  <= done_n;
        end
    end

    // Next-state logic; the line level is derived from the next state so the
    // registered TX changes on the same edge as the state it belongs to.
    always_comb begin
        state_n = state_q;
        baud_n  = baud_q;
        bit_n   = bit_q;
        byte_n  = byte_q;
        hold_n  = hold_q;
        done_n  = 1'b0;
        tx_n    = 1'b1;

        case (state_q)
            IDLE: begin
                if (valid_i) begin
                    hold_n  = sample_i;
                    state_n = START;
                    baud_n  = '0;
                    bit_n   = '0;
                    byte_n  = '0;
                end
            end
            START: begin
                if (bit_end) begin
                    baud_n  = '0;
                    bit_n   = '0;
                    state_n = DATA;
                end else begin
                    baud_n = baud_q + CW'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    baud_n = '0;
                    if (bit_q == 3'd7) begin
                        state_n = STOP;
                    end else begin
                        bit_n = bit_q + 3'd1;
                    end
                end else begin
                    baud_n = baud_q + CW'(1);
                end
            end
            STOP: begin
                if (bit_end) begin
                    baud_n = '0;
                    if (byte_q < 2'd2) begin
                        byte_n  = byte_q + 2'd1;
                        state_n = START;
                    end else begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                    end
                end else begin
                    baud_n = baud_q + CW'(1);
                end
            end
            default: state_n = IDLE;
        endcase

        case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = cur_byte[bit_n];
            default: tx_n = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_audio_uart_tx.sv
// tb_audio_uart_tx: directed and randomized frames checked cycle by cycle
// against a line-level model of the three-byte 8N1 framing.
`timescale 1ns/1ps
module tb_audio_uart_tx;

    localparam int DIV = 104;
    localparam int FRAME = 30 * DIV;

    logic        clk;
    logic        rst;
    logic [17:0] sample_i;
    logic        valid_i;
    logic        ready_o;
    logic        tx;
    logic        busy_o;
    logic        frame_done_o;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int dq[$];

    audio_uart_tx #(
        .CLK_FREQ(12_000_000),
        .BAUD(115_200),
        .DIV(DIV)
    ) dut (
        .CLK_IN(clk),
        .RST_i(rst),
        .sample_i(sample_i),
        .valid_i(valid_i),
        .ready_o(ready_o),
        .RS232_TX_o(tx),
        .busy_o(busy_o),
        .frame_done_o(frame_done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle count and frame_done pulse log, sampled away from the active edge.
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (frame_done_o === 1'b1) dq.push_back(cyc);
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Frame bit k (0..29): byte k/10, slot k%10 = start, d0..d7, stop.
    function automatic logic exp_bit(input logic [17:0] s, input int k);
        int b = k / 10;
        int p = k % 10;
        int word = int'(s);
        if (p == 0) return 1'b0;
        if (p == 9) return 1'b1;
        return (((word >> (8 * b)) >> (p - 1)) & 1) != 0;
    endfunction

    function automatic logic [7:0] exp_byte(input logic [17:0] s, input int b);
        int word = int'(s);
        return 8'((word >> (8 * b)) & 255);
    endfunction

    // Caller leaves valid_i high with sample s at a negedge; the accept edge
    // follows. Checks every cycle of the frame, decodes bytes at bit centres.
    task automatic run_frame(input logic [17:0] s, input bit chain, input logic [17:0] next_s,
                             input bit busy_pulse, input int abort_at,
                             output logic [7:0] b0, output logic [7:0] b1, output logic [7:0] b2);
        logic [29:0] mid;
        int wait_n;
        mid = '0;
        b0 = 'x; b1 = 'x; b2 = 'x;
        wait_n = 0;
        while (ready_o !== 1'b1 && wait_n < 10 * DIV) begin
            @(negedge clk);
            wait_n++;
        end
        check("accept_ready", 32'(ready_o), 1);
        @(posedge clk);
        @(negedge clk);
        valid_i = 1'b0;
        for (int m = 0; m < FRAME; m++) begin
            if (m == abort_at) return;
            check("tx", 32'(tx), 32'(exp_bit(s, m / DIV)));
            check("rdy_busy_done", {29'b0, ready_o, busy_o, frame_done_o}, 3'b010);
            if (m % DIV == DIV / 2) mid[m / DIV] = tx;
            if (m == 7) sample_i = 18'($urandom);
            if (busy_pulse && m >= 1000 && m < 1003) begin
                valid_i = 1'b1;
                sample_i = 18'd329;
            end
            if (busy_pulse && m == 1003) valid_i = 1'b0;
            if (chain && m == FRAME - 5) begin
                valid_i = 1'b1;
                sample_i = next_s;
            end
            @(negedge clk);
        end
        check("done_pulse", 32'(frame_done_o), 1);
        check("ready_after", 32'(ready_o), 1);
        check("busy_after", 32'(busy_o), 0);
        check("tx_idle_after", 32'(tx), 1);
        b0 = mid[8:1];
        b1 = mid[18:11];
        b2 = mid[28:21];
        if (!chain) begin
            @(negedge clk);
            check("done_one_cycle", 32'(frame_done_o), 0);
        end
    endtask

    task automatic check_bytes(input string tag, input logic [7:0] a0, input logic [7:0] a1,
                               input logic [7:0] a2, input logic [23:0] exp);
        check(tag, {8'b0, a2, a1, a0}, {8'b0, exp});
    endtask

    initial begin
        logic [7:0] b0, b1, b2;
        logic [17:0] s;
        int n0;

        rst = 1'b0;
        valid_i = 1'b0;
        sample_i = '0;

        // Asynchronous reset asserted between edges.
        #3 rst = 1'b1;
        #1;
        check("rst_tx", 32'(tx), 1);
        check("rst_ready", 32'(ready_o), 1);
        check("rst_busy", 32'(busy_o), 0);
        check("rst_done", 32'(frame_done_o), 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            check("idle_tx_done", {30'b0, tx, frame_done_o}, 2'b10);
        end

        // Single frame 440.
        valid_i = 1'b1; sample_i = 18'd440;
        run_frame(18'd440, 1'b0, '0, 1'b0, -1, b0, b1, b2);
        check_bytes("bytes_440", b0, b1, b2, 24'h0001B8);

        // Upper-bit masking.
        valid_i = 1'b1; sample_i = 18'h3FFFF;
        run_frame(18'h3FFFF, 1'b0, '0, 1'b0, -1, b0, b1, b2);
        check_bytes("bytes_3ffff", b0, b1, b2, 24'h03FFFF);

        // Back-to-back frames with valid held.
        n0 = dq.size();
        valid_i = 1'b1; sample_i = 18'd261;
        run_frame(18'd261, 1'b1, 18'd293, 1'b0, -1, b0, b1, b2);
        check_bytes("bytes_261", b0, b1, b2, 24'h000105);
        run_frame(18'd293, 1'b0, '0, 1'b0, -1, b0, b1, b2);
        check_bytes("bytes_293", b0, b1, b2, 24'h000125);
        check("b2b_done_count", 32'(dq.size() - n0), 2);
        if (dq.size() >= 2) check("b2b_done_spacing", 32'(dq[dq.size()-1] - dq[dq.size()-2]), FRAME + 1);

        // Valid pulsed while busy must not produce a second frame.
        n0 = dq.size();
        s = 18'($urandom);
        valid_i = 1'b1; sample_i = s;
        run_frame(s, 1'b0, '0, 1'b1, -1, b0, b1, b2);
        check_bytes("bytes_busy", b0, b1, b2, {exp_byte(s, 2), exp_byte(s, 1), exp_byte(s, 0)});
        for (int i = 0; i < 2 * DIV; i++) begin
            @(negedge clk);
            check("no_extra_frame", {30'b0, tx, ready_o}, 2'b11);
        end
        check("busy_done_count", 32'(dq.size() - n0), 1);

        // Randomized frames.
        for (int r = 0; r < 3; r++) begin
            s = 18'($urandom);
            valid_i = 1'b1; sample_i = s;
            run_frame(s, 1'b0, '0, 1'b0, -1, b0, b1, b2);
            check_bytes("bytes_rand", b0, b1, b2, {exp_byte(s, 2), exp_byte(s, 1), exp_byte(s, 0)});
        end

        // Reset during B1 data bits.
        n0 = dq.size();
        s = 18'($urandom);
        valid_i = 1'b1; sample_i = s;
        run_frame(s, 1'b0, '0, 1'b0, 13 * DIV + 20, b0, b1, b2);
        #2 rst = 1'b1;
        #1;
        check("midrst_tx", 32'(tx), 1);
        check("midrst_ready", 32'(ready_o), 1);
        check("midrst_busy", 32'(busy_o), 0);
        check("midrst_done", 32'(frame_done_o), 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 2 * DIV; i++) begin
            @(negedge clk);
            check("post_rst_idle", {30'b0, tx, frame_done_o}, 2'b10);
        end
        check("midrst_no_done", 32'(dq.size() - n0), 0);
        valid_i = 1'b1; sample_i = 18'd349;
        run_frame(18'd349, 1'b0, '0, 1'b0, -1, b0, b1, b2);
        check_bytes("bytes_349", b0, b1, b2, 24'h00015D);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
